conv_window3x3: RTL and testbench

CONV_WINDOW3X3 -- requirements
Module: conv_window3x3

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_line_fifo.sv | 30 +++
 rtl/conv_window3x3.sv | 149 ++++++++++++++
 tb/tb_conv_window3x3.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front-end: default pixel width,
// default maximum line width, the pixel type and a dimension clamp helper.
package conv_pkg;

    localparam int unsigned CONV_DATA_W = 16;
    localparam int unsigned CONV_MAX_W  = 128;
    localparam int unsigned WIN_TAPS    = 9;

    typedef logic signed [CONV_DATA_W-1:0] pixel_t;

    // Clamp a frame dimension into 3..hi (a window needs at least 3 taps).
    function automatic logic [7:0] clamp_dim(input logic [7:0] v, input logic [7:0] hi);
        if (v < 8'd3) begin
            return 8'd3;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/conv_line_fifo.sv
// One line delay: a single RAM row addressed by column. The read is
// combinational from the current contents, so a same-cycle write at the
// same address returns the previous line's pixel (read-before-write).
// Memory is intentionally not reset; stale contents are never emitted.
module conv_line_fifo
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int DEPTH  = CONV_MAX_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Store the incoming pixel for use one line later.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window3x3.sv
// 3x3 sliding window generator over a padded pixel stream.
// Two line delays supply the two older rows; a 3x3 register array shifts
// one column per accepted pixel. A window is published only when the
// current pixel is at row>=2 and col>=2, so windows never straddle a line
// or frame boundary.
// Optional build macro CONV_WINDOW_FRAME_DONE_EN adds o_frame_done, pulsed
// together with the last window of each frame.
module conv_window3x3
    import conv_pkg::*;
#(
    parameter int DATA_W = $bits(pixel_t),
    parameter int MAX_W  = CONV_MAX_W
) (
    input  logic                          p_clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_valid,
    input  logic [7:0]                    line_width,
    input  logic [7:0]                    line_height,
    output logic [WIN_TAPS*DATA_W-1:0]    o_window,
    output logic                          o_valid
`ifdef CONV_WINDOW_FRAME_DONE_EN
    ,output logic                         o_frame_done
`endif
);

    localparam int AW = $clog2(MAX_W);
    localparam logic [7:0] MAX_W8 = 8'(MAX_W);

    logic [7:0] col_q, col_d, row_q, row_d;
    logic [7:0] w_q, w_d, h_q, h_d;
    logic [DATA_W-1:0] win_q [WIN_TAPS];
    logic [DATA_W-1:0] win_d [WIN_TAPS];
    logic [WIN_TAPS*DATA_W-1:0] owin_q, owin_d;
    logic o_valid_q, o_valid_d;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic first_px, last_col, last_row;
    logic [7:0] w_eff, h_eff;
`ifdef CONV_WINDOW_FRAME_DONE_EN
    logic fd_q, fd_d;
`endif

    // Row 1 line delay (previous line) and row 0 line delay (two lines back).
    conv_line_fifo #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_lb1 (
        .clk     (p_clk),
        .wr_en   (i_valid),
        .addr    (col_q[AW-1:0]),
        .wr_data (i_data),
        .rd_data (lb1_rd)
    );

    conv_line_fifo #(.DATA_W(DATA_W), .DEPTH(MAX_W)) u_lb2 (
        .clk     (p_clk),
        .wr_en   (i_valid),
        .addr    (col_q[AW-1:0]),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    // Position tracking, window shift and output staging for each accepted pixel.
    always_comb begin
        // Dimensions are taken from the ports only on the frame's first pixel.
        first_px = (col_q == 8'd0) && (row_q == 8'd0);
        w_eff    = first_px ? clamp_dim(line_width, MAX_W8) : w_q;
        h_eff    = first_px ? clamp_dim(line_height, 8'd255) : h_q;
        last_col = (col_q == w_eff - 8'd1);
        last_row = (row_q == h_eff - 8'd1);

        col_d     = col_q;
        row_d     = row_q;
        w_d       = w_q;
        h_d       = h_q;
        owin_d    = owin_q;
        o_valid_d = 1'b0;
        for (int k = 0; k < WIN_TAPS; k++) begin
            win_d[k] = win_q[k];
        end
`ifdef CONV_WINDOW_FRAME_DONE_EN
        fd_d = 1'b0;
`endif

        if (i_valid) begin
            w_d = w_eff;
            h_d = h_eff;
            if (last_col) begin
                col_d = 8'd0;
                row_d = last_row ? 8'd0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = i_data;

            if ((row_q >= 8'd2) && (col_q >= 8'd2)) begin
                o_valid_d = 1'b1;
                for (int k = 0; k < WIN_TAPS; k++) begin
                    owin_d[DATA_W*k +: DATA_W] = win_d[k];
                end
`ifdef CONV_WINDOW_FRAME_DONE_EN
                fd_d = last_col && last_row;
`endif
            end
        end
    end

    // State registers; line-buffer RAM lives in the sub-modules and is unreset.
    always_ff @(posedge p_clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            owin_q    <= '0;
            o_valid_q <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= '0;
            end
`ifdef CONV_WINDOW_FRAME_DONE_EN
            fd_q      <= 1'b0;
`endif
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            w_q       <= w_d;
            h_q       <= h_d;
            owin_q    <= owin_d;
            o_valid_q <= o_valid_d;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= win_d[k];
            end
`ifdef CONV_WINDOW_FRAME_DONE_EN
            fd_q      <= fd_d;
`endif
        end
    end

    assign o_window = owin_q;
    assign o_valid  = o_valid_q;
`ifdef CONV_WINDOW_FRAME_DONE_EN
    assign o_frame_done = fd_q;
`endif

endmodule

// File: tb/tb_conv_window3x3.sv
// Bench for conv_window3x3: directed ramp frames, alternating and random
// valid gaps, back-to-back frames, mid-frame reset, width clamping and
// random frames, all checked against a row-buffer reference model.
module tb_conv_window3x3;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int MW = 128;
    localparam int WW = 9 * DW;

    logic           p_clk = 1'b0;
    logic           rst = 1'b0;
    logic [DW-1:0]  i_data = '0;
    logic           i_valid = 1'b0;
    logic [7:0]     line_width = 8'd5;
    logic [7:0]     line_height = 8'd5;
    logic [WW-1:0]  o_window;
    logic           o_valid;
`ifdef CONV_WINDOW_FRAME_DONE_EN
    logic           o_frame_done;
`endif

    always #5 p_clk = ~p_clk;

    conv_window3x3 #(.DATA_W(DW), .MAX_W(MW)) dut (
        .p_clk       (p_clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .line_width  (line_width),
        .line_height (line_height),
        .o_window    (o_window),
        .o_valid     (o_valid)
`ifdef CONV_WINDOW_FRAME_DONE_EN
        ,.o_frame_done (o_frame_done)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: expected windows and whether each is the frame's last.
    logic [WW-1:0] exp_q [$];
    bit            last_q [$];

    // Reference model: last three rows of the current frame.
    logic [DW-1:0] rows [3][MW];

    logic [WW-1:0] held = '0;
    logic [WW-1:0] first_win = '0;
    logic [WW-1:0] last_win = '0;
    logic [WW-1:0] win10 = '0;
    int            n_win = 0;
    int            n_fd = 0;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Ramp-frame window whose bottom-right pixel is (r,c).
    function automatic logic [WW-1:0] ramp_win(input int base, input int w, input int r, input int c);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[DW*(3*i+j) +: DW] = DW'(base + (r - 2 + i) * w + (c - 2 + j));
            end
        end
        return v;
    endfunction

    // Monitor / scoreboard, sampled away from the active edge.
    always @(negedge p_clk) begin
        logic [WW-1:0] e;
        bit            lst;
        if (!rst) begin
            check_val("rst_valid", WW'(o_valid), '0);
            check_val("rst_window", o_window, '0);
            held = '0;
        end else if (o_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", WW'(o_valid), '0);
            end else begin
                e   = exp_q.pop_front();
                lst = last_q.pop_front();
                check_val("window", o_window, e);
`ifdef CONV_WINDOW_FRAME_DONE_EN
                check_val("frame_done", WW'(o_frame_done), WW'(lst));
`else
                lst = 1'b0;
`endif
            end
            n_win++;
            if (n_win == 1) first_win = o_window;
            if (n_win == 10) win10 = o_window;
            last_win = o_window;
            held = o_window;
        end else begin
            check_val("hold", o_window, held);
`ifdef CONV_WINDOW_FRAME_DONE_EN
            check_val("frame_done_idle", WW'(o_frame_done), '0);
`endif
        end
`ifdef CONV_WINDOW_FRAME_DONE_EN
        if (rst && o_frame_done) n_fd++;
`endif
    end

    // Drive one frame; stop_after >= 0 ends early after that many pixels.
    task automatic drive_frame(input int wp, input int hp, input bit ramp, input int base,
                               input int gap_mode, input int stop_after, input bit scramble);
        int w, h, n, gaps;
        logic [DW-1:0] d;
        logic [WW-1:0] win;
        w = (wp < 3) ? 3 : ((wp > MW) ? MW : wp);
        h = (hp < 3) ? 3 : hp;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (stop_after >= 0 && n == stop_after) return;
                gaps = (gap_mode == 1) ? ((n == 0) ? 0 : 1) :
                       (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < gaps; g++) begin
                    i_valid = 1'b0;
                    @(posedge p_clk); #1;
                end
                if (r == 0 && c == 0) begin
                    line_width  = 8'(wp);
                    line_height = 8'(hp);
                end else if (scramble) begin
                    line_width  = 8'($urandom);
                    line_height = 8'($urandom);
                end
                d = ramp ? DW'(base + r * w + c) : DW'($urandom);
                rows[r % 3][c] = d;
                if (r >= 2 && c >= 2) begin
                    win = '0;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            win[DW*(3*i+j) +: DW] = rows[(r - 2 + i) % 3][c - 2 + j];
                        end
                    end
                    exp_q.push_back(win);
                    last_q.push_back((r == h - 1) && (c == w - 1));
                end
                i_data  = d;
                i_valid = 1'b1;
                @(posedge p_clk); #1;
                n++;
            end
        end
    endtask

    task automatic drain();
        i_valid = 1'b0;
        repeat (3) @(posedge p_clk);
        #1;
        check_val("drain", WW'(exp_q.size()), '0);
        exp_q.delete();
        last_q.delete();
    endtask

    task automatic pulse_reset_check();
        i_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_val("reset_now_valid", WW'(o_valid), '0);
        check_val("reset_now_window", o_window, '0);
        exp_q.delete();
        last_q.delete();
        @(posedge p_clk); #1;
        rst = 1'b1;
        @(posedge p_clk); #1;
    endtask

    task automatic ramp_5x5_check(input string tag);
        n_win = 0;
        n_fd  = 0;
        drive_frame(5, 5, 1'b1, 0, 0, -1, 1'b0);
        drain();
        check_val({tag, "_count"}, WW'(n_win), WW'(9));
        check_val({tag, "_first"}, first_win, ramp_win(0, 5, 2, 2));
        check_val({tag, "_last_centre"}, WW'(last_win[4*DW +: DW]), WW'(18));
`ifdef CONV_WINDOW_FRAME_DONE_EN
        check_val({tag, "_frame_done_count"}, WW'(n_fd), WW'(1));
`endif
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge p_clk);
        #1;
        check_val("init_valid", WW'(o_valid), '0);
        check_val("init_window", o_window, '0);
        rst = 1'b1;
        @(posedge p_clk); #1;

        // Continuous 5x5 ramp.
        ramp_5x5_check("ramp");

        // Same ramp with i_valid every other cycle and ports changing mid-frame.
        n_win = 0;
        drive_frame(5, 5, 1'b1, 0, 1, -1, 1'b1);
        drain();
        check_val("alt_count", WW'(n_win), WW'(9));
        check_val("alt_first", first_win, ramp_win(0, 5, 2, 2));
        check_val("alt_last_centre", WW'(last_win[4*DW +: DW]), WW'(18));

        // Two back-to-back frames.
        n_win = 0;
        drive_frame(5, 5, 1'b1, 0, 0, -1, 1'b0);
        drive_frame(5, 5, 1'b1, 100, 0, -1, 1'b0);
        drain();
        check_val("b2b_count", WW'(n_win), WW'(18));
        check_val("b2b_f2_first", win10, ramp_win(100, 5, 2, 2));

        // Reset after pixel 8, then a fresh ramp.
        drive_frame(5, 5, 1'b1, 0, 0, 9, 1'b0);
        pulse_reset_check();
        ramp_5x5_check("rst8");

        // Reset after pixel 18 while a window is on the output.
        drive_frame(5, 5, 1'b1, 0, 0, 19, 1'b0);
        pulse_reset_check();
        ramp_5x5_check("rst18");

        // Width clamp: 200 requested, 128 used.
        n_win = 0;
        drive_frame(200, 3, 1'b1, 0, 0, -1, 1'b0);
        drain();
        check_val("clamp_count", WW'(n_win), WW'(126));
        check_val("clamp_first_centre", WW'(first_win[4*DW +: DW]), WW'(129));
        check_val("clamp_last_centre", WW'(last_win[4*DW +: DW]), WW'(254));

        // Random frames with random sizes, data and gaps, back-to-back.
        for (int f = 0; f < 10; f++) begin
            drive_frame(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                        1'b0, 0, 2, -1, 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
